// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the byte-enabled data memory.
//   DATA_W         : memory word width (fixed at 32 in this generation)
//   MOP_*          : mem_op access-type encodings
//   state_e        : clear/ready FSM state
package dmem_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] MOP_W  = 3'b000;  // word
  localparam logic [2:0] MOP_HU = 3'b001;  // half, zero-extended
  localparam logic [2:0] MOP_HS = 3'b010;  // half, sign-extended
  localparam logic [2:0] MOP_BU = 3'b011;  // byte, zero-extended
  localparam logic [2:0] MOP_BS = 3'b100;  // byte, sign-extended

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane -- purely combinational lane logic for dmem_be.
//   mem_op_i   : access type (dmem_pkg MOP_* encodings)
//   addr_lo_i  : byte offset within the word (addr[1:0])
//   wdata_i    : right-aligned store data
//   word_i     : current contents of the addressed word
//   addr_err_o : misaligned access or illegal mem_op
//   merged_o   : word_i with the enabled store lanes replaced
//   load_o     : extracted and extended load value, zero on error
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]        mem_op_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] word_i,
  output logic              addr_err_o,
  output logic [DATA_W-1:0] merged_o,
  output logic [DATA_W-1:0] load_o
);

  logic [3:0]        be_s;
  logic [DATA_W-1:0] wlane_s;
  logic [15:0]       half_s;
  logic [7:0]        byte_s;

  // Decode access type: error flag, byte enables, replicated store data, load extension.
  always_comb begin
    addr_err_o = 1'b0;
    be_s       = 4'b0000;
    wlane_s    = {DATA_W{1'b0}};
    load_o     = {DATA_W{1'b0}};
    half_s     = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    byte_s     = word_i[{addr_lo_i, 3'b000} +: 8];
    case (mem_op_i)
      MOP_W: begin
        addr_err_o = (addr_lo_i != 2'b00);
        be_s       = 4'b1111;
        wlane_s    = wdata_i;
        load_o     = word_i;
      end
      MOP_HU, MOP_HS: begin
        addr_err_o = addr_lo_i[0];
        be_s       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        // Store data is replicated to every lane; be_s picks the one written.
        wlane_s    = {2{wdata_i[15:0]}};
        if (mem_op_i == MOP_HS) begin
          load_o = {{16{half_s[15]}}, half_s};
        end else begin
          load_o = {16'h0000, half_s};
        end
      end
      MOP_BU, MOP_BS: begin
        addr_err_o = 1'b0;
        be_s       = 4'b0001 << addr_lo_i;
        wlane_s    = {4{wdata_i[7:0]}};
        if (mem_op_i == MOP_BS) begin
          load_o = {{24{byte_s[7]}}, byte_s};
        end else begin
          load_o = {24'h000000, byte_s};
        end
      end
      default: begin
        addr_err_o = 1'b1;
      end
    endcase
    if (addr_err_o) begin
      be_s   = 4'b0000;
      load_o = {DATA_W{1'b0}};
    end else begin
      be_s   = be_s;
      load_o = load_o;
    end
  end

  // Read-modify-write merge: enabled lanes take store data, others keep the old word.
  always_comb begin
    merged_o = word_i;
    for (int k = 0; k < 4; k++) begin
      if (be_s[k]) begin
        merged_o[8*k +: 8] = wlane_s[8*k +: 8];
      end else begin
        merged_o[8*k +: 8] = word_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_be.sv
// dmem_be -- byte-enabled data memory with self-clearing after reset.
//   clk      : clock, all state updates on rising edge
//   reset    : synchronous active-high reset, restarts the clear sequence
//   we       : store request for the current cycle
//   mem_op   : access type (dmem_pkg MOP_* encodings)
//   addr     : byte address; word index addr[ADDR_W+1:2], upper bits wrap
//   wdata    : right-aligned store data
//   pc       : PC of the requesting instruction (trace only)
//   rdata    : zero-latency load result, zero while busy or on error
//   busy     : high during reset and while the memory is being cleared
//   addr_err : combinational misaligned / illegal-op flag
// Build option: define DMEM_TRACE_EN to print each committed store as
//   "@<pc>: *<word-aligned byte addr> <= <merged word>".
module dmem_be #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        addr_err
);

  import dmem_pkg::*;

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] rd_idx_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] merged_s;
  logic [DATA_W-1:0] load_s;
  logic              commit_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;

  assign rd_idx_s  = addr[ADDR_W+1:2];
  assign rd_word_s = mem_q[rd_idx_s];

  dmem_lane u_lane (
    .mem_op_i   (mem_op),
    .addr_lo_i  (addr[1:0]),
    .wdata_i    (wdata),
    .word_i     (rd_word_s),
    .addr_err_o (addr_err),
    .merged_o   (merged_s),
    .load_o     (load_s)
  );

  assign busy     = reset | (state_q != ST_READY);
  assign rdata    = busy ? 32'h0000_0000 : load_s;
  assign commit_s = we & ~busy & ~addr_err;

  // Clear sequencer: walk every word once after reset, then serve accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + ONE_IDX;
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_READY;
          end else begin
            state_q <= ST_CLEAR;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // Single write port shared between the clear walk and committed stores.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = rd_idx_s;
    wr_data_s = merged_s;
    if (reset) begin
      wr_en_s = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = cnt_q;
      wr_data_s = {DATA_W{1'b0}};
    end else begin
      wr_en_s = commit_s;
    end
  end

  // Storage array; no reset, contents are defined by the clear walk.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= wr_data_s;
    end
  end

  logic unused_addr_s;
  assign unused_addr_s = ^addr[31:ADDR_W+2];

`ifdef DMEM_TRACE_EN
  // Store trace, printed on the commit edge.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_s);
    end
  end
`else
  logic unused_pc_s;
  assign unused_pc_s = ^pc;
`endif

endmodule

// File: tb/tb_dmem_be.sv
// tb_dmem_be -- directed self-checking bench for dmem_be (ADDR_W=10).
module tb_dmem_be;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        busy;
  logic        addr_err;

  int n_checks;
  int n_fail;

  dmem_be #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .mem_op   (mem_op),
    .addr     (addr),
    .wdata    (wdata),
    .pc       (pc),
    .rdata    (rdata),
    .busy     (busy),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; mem_op = op; addr = a; wdata = d; pc = pc + 32'd4;
    tick();
    we = 1'b0;
  endtask

  task automatic check_load(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] exp);
    we = 1'b0; mem_op = op; addr = a;
    @(negedge clk);
    check(tag, rdata, exp);
    tick();
  endtask

  // Count consecutive cycles with busy high; the first cycle may carry a store.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      cnt++;
      tick();
      we = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    int bad;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; we = 1'b0; mem_op = 3'b000; addr = 32'h0; wdata = 32'h0; pc = 32'h0;

    // Reset state
    #1;
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_rdata", rdata, 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("clear_rdata", rdata, 32'h0);
    #4;
    count_busy(cnt);
    check("busy_len", cnt, 32'd1024);
    check("ready_busy", {31'd0, busy}, 32'd0);

    // Every word cleared
    bad = 0;
    mem_op = 3'b000;
    for (int i = 0; i < 1024; i++) begin
      addr = i * 4;
      @(negedge clk);
      if (rdata !== 32'h0) bad++;
    end
    check("clear_all_zero", bad, 32'd0);
    tick();

    // Word then byte store, lane merge and extension
    store(3'b000, 32'h10, 32'h12345678);
    store(3'b011, 32'h11, 32'h000000AB);
    check_load("word_merge",  3'b000, 32'h10, 32'h1234AB78);
    check_load("byte_signed", 3'b100, 32'h11, 32'hFFFFFFAB);
    check_load("byte_uns",    3'b011, 32'h11, 32'h000000AB);
    check_load("byte_pos_s",  3'b100, 32'h10, 32'h00000078);
    check_load("byte_hi",     3'b011, 32'h13, 32'h00000012);

    // Half store in upper lane
    store(3'b001, 32'h22, 32'h00008001);
    check_load("half_signed", 3'b010, 32'h22, 32'hFFFF8001);
    check_load("half_uns",    3'b001, 32'h22, 32'h00008001);
    check_load("half_word",   3'b000, 32'h20, 32'h80010000);

    // Misaligned and illegal accesses
    we = 1'b1; mem_op = 3'b000; addr = 32'h05; wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("mis_word_err", {31'd0, addr_err}, 32'd1);
    check("mis_word_rd", rdata, 32'h0);
    tick();
    we = 1'b0;
    check_load("mis_no_write", 3'b000, 32'h04, 32'h0);
    mem_op = 3'b111; addr = 32'h0;
    @(negedge clk);
    check("op111_err", {31'd0, addr_err}, 32'd1);
    mem_op = 3'b001; addr = 32'h21;
    @(negedge clk);
    check("mis_half_err", {31'd0, addr_err}, 32'd1);
    mem_op = 3'b010; addr = 32'h22;
    @(negedge clk);
    check("half_ok_err", {31'd0, addr_err}, 32'd0);
    tick();

    // Address wrap and same-cycle read-during-write
    store(3'b000, 32'h0, 32'h00000001);
    we = 1'b1; mem_op = 3'b000; addr = 32'h1000; wdata = 32'h00000002;
    @(negedge clk);
    check("rdw_old", rdata, 32'h00000001);
    tick();
    we = 1'b0;
    check_load("wrap_new", 3'b000, 32'h0, 32'h00000002);

    // Reset pulsed mid-clear; store during busy is lost
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    check("mid_clear_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; mem_op = 3'b000; addr = 32'h10;
    @(negedge clk);
    check("rst_pulse_busy", {31'd0, busy}, 32'd1);
    check("rst_pulse_rd", rdata, 32'h0);
    tick();
    reset = 1'b0;
    we = 1'b1; mem_op = 3'b000; addr = 32'h40; wdata = 32'hCAFEF00D;
    count_busy(cnt);
    check("busy_len2", cnt, 32'd1024);
    check_load("busy_store_lost", 3'b000, 32'h40, 32'h0);
    check_load("recleared", 3'b000, 32'h10, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_be.md
DMEM_BE -- requirements
Module: dmem_be

Interface
REQ-001 Parameter ADDR_W, default 10, meaning word-address width; DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, meaning word width; fixed at 32 in this generation.
REQ-003 Port clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port we  input  1  store request for the current cycle.
REQ-006 Port mem_op  input  3  access type: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed.
REQ-007 Port addr  input  32  byte address.
REQ-008 Port wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
REQ-009 Port pc  input  32  PC of the requesting instruction, used for the trace only.
REQ-010 Port rdata  output  32  load result, extended per mem_op.
REQ-011 Port busy  output  1  high while the memory is being cleared.
REQ-012 Port addr_err  output  1  combinational misaligned or illegal-op flag.

Function
REQ-013 FSM states: CLEAR and READY; reset forces CLEAR with clear counter 0.
REQ-014 CLEAR writes zero to word[counter] each cycle; counter increments; CLEAR -> READY after writing word DEPTH-1, so busy is high for exactly DEPTH cycles after reset deasserts.
REQ-015 busy = 1 in CLEAR and while reset is high; busy = 0 in READY.
REQ-016 In CLEAR, store requests are dropped and rdata = 0.
REQ-017 Word index = addr[ADDR_W+1:2]; higher address bits are ignored, so out-of-range addresses wrap.
REQ-018 Lanes are little-endian: byte lane k = bits [8k+7:8k], selected by addr[1:0]; half lane selected by addr[1].
REQ-019 Stores are read-modify-write of the enabled lanes only; other lanes keep their value.
REQ-020 addr_err = 1 for: word with addr[1:0] != 0; half with addr[0] != 0; mem_op 101, 110 or 111.
REQ-021 When addr_err = 1, the store is suppressed and rdata = 0.
REQ-022 A store commits on the rising edge when we = 1, state is READY, addr_err = 0 and reset = 0.
REQ-023 Read has zero latency: rdata is combinational from the addressed word.
REQ-024 Same-cycle read and write to the same word returns the old word; the new value is visible from the next cycle.
REQ-025 Loads: byte and half extract the addressed lane, then zero-extend or sign-extend per mem_op.

Reset
REQ-026 reset asserted in any state, including mid-CLEAR, restarts CLEAR from counter 0.
REQ-027 While reset is high: busy = 1, rdata = 0, no store commits.
REQ-028 Memory contents are undefined until the first CLEAR completes; contents are not preloaded.

Configuration
REQ-029 Macro DMEM_TRACE_EN defined: every committed store prints "@<pc hex>: *<byte addr hex, word aligned> <= <merged 32-bit word hex>" in the same cycle.
REQ-030 Macro DMEM_TRACE_EN undefined: no simulation output and identical RTL behaviour otherwise.

Structure
REQ-031 Package dmem_pkg holds the mem_op encodings (MOP_W, MOP_HU, MOP_HS, MOP_BU, MOP_BS), the FSM state typedef and the DATA_W constant.
REQ-032 Sub-module dmem_lane performs lane selection, byte-enable generation, write merge, load extension and addr_err decode; it is purely combinational and instantiated once.
REQ-033 Storage is a single DEPTH x 32 array with one write port, owned by dmem_be.

Verification
REQ-034 Reset 1 cycle, then idle -> busy high exactly 1024 cycles with ADDR_W=10, then low; every word reads 0.
REQ-035 Store word 0x12345678 @0x10, then byte 0xAB @0x11 -> word load @0x10 = 0x1234AB78; byte-signed load @0x11 = 0xFFFFFFAB; byte-unsigned load @0x11 = 0x000000AB.
REQ-036 Store half 0x8001 @0x22 -> half-signed load @0x22 = 0xFFFF8001; half-unsigned load = 0x00008001; word load @0x20 = 0x80010000.
REQ-037 Word store 0xDEADBEEF @0x05 -> addr_err = 1, no write, rdata = 0; mem_op 111 -> addr_err = 1.
REQ-038 Reset pulsed at clear cycle 500 -> busy stays high 1024 further cycles; a store issued during busy is lost.
REQ-039 Store 0x1 @0x0 and 0x2 @0x1000 (wraps to word 0 with ADDR_W=10) -> word 0 = 0x2; same-cycle read returned the old value.
